periph_router: RTL and testbench

- Parametrised successor to the fixed peripheral decoder: routes one master request to one of NUM_SLAVES peripheral slots on flattened slave buses.
- Adds a ready/ack handshake, wait-state support, a per-access timeout and bus-error reporting.
- Sits between the core's memory-mapped peripheral window and the peripheral modules (debug, uart, timers, spi, gpio, ...).

---
 rtl/periph_router.sv | 185 ++++++++++++++++++
 tb/tb_periph_router.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_router.sv
// Routes one master access to one of NUM_SLAVES slots; optional status block under PERIPH_ROUTER_STATUS_EN.
// Latency: ack at T+2 (zero-wait/unmapped/status), T+2+k with k slave wait cycles, T+1+TIMEOUT on timeout.
// Backpressure: ready low while an access is in flight; requests seen then are dropped (sticky flag).
module periph_router #(
    parameter int          NUM_SLAVES = 8,
    parameter int          FIRST_SLOT = 1,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [13:0]              address,
    input  logic [31:0]              write_data,
    input  logic                     we,
    input  logic                     re,
    output logic                     ready,
    output logic                     ack,
    output logic                     bus_err,
    output logic [31:0]              read_data,
    output logic [7:0]               s_addr,
    output logic [31:0]              s_wdata,
    output logic [NUM_SLAVES-1:0]    s_we,
    output logic [NUM_SLAVES-1:0]    s_re,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [4:0]            slot, slot_q, ch_q;
    logic                  req, accept, mapped_hit, stat_hit;
    logic                  dir_we_q, map_q, stat_q, err_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_SLAVES-1:0] sel_vec;
    logic [31:0]           rdata_sel, stat_rd;
    logic                  rdy_sel, err_ev, to_ev, cap_ev;
    logic                  unused_addr_msb;

    assign unused_addr_msb = address[13];
    assign slot       = address[12:8];
    assign req        = re | we;
    assign ready      = (state_q == IDLE) || (state_q == DONE);
    assign accept     = req & ready;
    assign mapped_hit = ({27'd0, slot} >= 32'(FIRST_SLOT)) &&
                        (({27'd0, slot} - 32'(FIRST_SLOT)) < 32'(NUM_SLAVES));

    always_comb begin
        sel_vec   = '0;
        rdata_sel = '0;
        rdy_sel   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_vec[i] = (ch_q == 5'(i));
            if (ch_q == 5'(i)) begin
                rdata_sel = s_rdata[32*i +: 32];
                rdy_sel   = s_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Unmapped and status accesses still spend one cycle in STROBE (strobes masked) so every
    // non-waiting access acks at T+2.
    always_comb begin
        state_d = state_q;
        err_ev  = 1'b0;
        to_ev   = 1'b0;
        cap_ev  = 1'b0;
        case (state_q)
            IDLE:   if (req) state_d = STROBE;
            STROBE: begin
                if (stat_q) begin
                    state_d = DONE;
                    cap_ev  = 1'b1;
                end else if (!map_q) begin
                    state_d = DONE;
                    err_ev  = 1'b1;
                end else if (rdy_sel) begin
                    state_d = DONE;
                    cap_ev  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rdy_sel) begin
                    state_d = DONE;
                    cap_ev  = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = DONE;
                    err_ev  = 1'b1;
                    to_ev   = 1'b1;
                end
            end
            DONE:    state_d = req ? STROBE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_addr    <= '0;
            s_wdata   <= '0;
            dir_we_q  <= 1'b0;
            slot_q    <= '0;
            ch_q      <= '0;
            map_q     <= 1'b0;
            stat_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            read_data <= '0;
        end else begin
            if (accept) begin
                s_addr   <= address[7:0];
                s_wdata  <= write_data;
                dir_we_q <= we;
                slot_q   <= slot;
                ch_q     <= slot - 5'(FIRST_SLOT);
                map_q    <= mapped_hit & ~stat_hit;
                stat_q   <= stat_hit;
                cnt_q    <= CW'(1);
            end else if (state_d == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (err_ev || cap_ev) begin
                err_q <= err_ev;
                if (!dir_we_q)
                    read_data <= err_ev ? ERR_DATA : (stat_q ? stat_rd : rdata_sel);
            end
        end
    end

    assign ack     = (state_q == DONE);
    assign bus_err = ack & err_q;
    assign s_we    = (state_q == STROBE && map_q &&  dir_we_q) ? sel_vec : '0;
    assign s_re    = (state_q == STROBE && map_q && !dir_we_q) ? sel_vec : '0;

`ifdef PERIPH_ROUTER_STATUS_EN
    logic [7:0] err_cnt_q;
    logic       last_to_q, dropped_q, stat_clr;
    logic [4:0] last_slot_q;

    assign stat_hit = (slot == 5'd0);
    assign stat_clr = (state_q == STROBE) && stat_q && dir_we_q && (s_addr == 8'h00);

    // A drop landing on the same edge as a clear survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= '0;
            last_to_q   <= 1'b0;
            dropped_q   <= 1'b0;
            last_slot_q <= '0;
        end else begin
            if (stat_clr) begin
                err_cnt_q   <= '0;
                last_to_q   <= 1'b0;
                dropped_q   <= 1'b0;
                last_slot_q <= '0;
            end else if (err_ev) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                last_to_q   <= to_ev;
                last_slot_q <= slot_q;
            end
            if (req && !ready) dropped_q <= 1'b1;
        end
    end

    always_comb begin
        stat_rd = '0;
        case (s_addr)
            8'h00:   stat_rd = {11'd0, last_slot_q, 6'd0, dropped_q, last_to_q, err_cnt_q};
            8'h04:   stat_rd = 32'(NUM_SLAVES);
            default: stat_rd = '0;
        endcase
    end
`else
    assign stat_hit = 1'b0;
    assign stat_rd  = '0;
`endif
endmodule

// File: tb/tb_periph_router.sv
// Randomized bench for periph_router: transaction-level model predicts ack cycle, error and data.
module tb_periph_router;
    localparam int NS = 8;
    localparam int FS = 1;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [13:0]     address;
    logic [31:0]     write_data;
    logic            we, re;
    logic            ready, ack, bus_err;
    logic [31:0]     read_data;
    logic [7:0]      s_addr;
    logic [31:0]     s_wdata;
    logic [NS-1:0]   s_we, s_re, s_ready;
    logic [32*NS-1:0] s_rdata;

    periph_router #(.NUM_SLAVES(NS), .FIRST_SLOT(FS), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .we(we), .re(re), .ready(ready), .ack(ack), .bus_err(bus_err),
        .read_data(read_data), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_we(s_we), .s_re(s_re), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // In-flight access as seen by the model: accept cycle, ack cycle and outcome.
    bit          inflight;
    int          tT, tA, t_ch, t_k;
    bit          t_we, t_map, t_stat, t_err, t_to;
    logic [4:0]  t_slot;
    logic [7:0]  t_off;
    logic [31:0] t_wd, t_val;

    logic          exp_ready, exp_ack, exp_err;
    logic [31:0]   exp_rd, cur_wd;
    logic [7:0]    cur_off;
    logic [NS-1:0] exp_we, exp_re;

    int          m_cnt;
    bit          m_to, m_drop;
    logic [4:0]  m_slot;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] stat_val(input logic [7:0] off);
        logic [31:0] v;
        v = 32'd0;
        if (off == 8'h00) begin
            v[7:0]   = 8'(m_cnt);
            v[8]     = m_to;
            v[9]     = m_drop;
            v[20:16] = m_slot;
        end else if (off == 8'h04) begin
            v = NS;
        end
        return v;
    endfunction

    task automatic model_reset();
        inflight  = 1'b0;
        exp_rd    = '0;
        cur_off   = '0;
        cur_wd    = '0;
        exp_ready = 1'b1;
        exp_ack   = 1'b0;
        exp_err   = 1'b0;
        exp_we    = '0;
        exp_re    = '0;
        m_cnt     = 0;
        m_to      = 1'b0;
        m_drop    = 1'b0;
        m_slot    = '0;
    endtask

    // One clock cycle: derive expectations for this cycle, drive slaves and the request.
    task automatic step(input bit r, input bit w, input logic [13:0] a, input logic [31:0] wd,
                        input int k, input logic [31:0] rdv);
        int slot;
        @(posedge clk);
        #1;
        cyc++;
        if (inflight && cyc > tA) inflight = 1'b0;
        exp_ready = !(inflight && cyc > tT && cyc < tA);
        exp_ack   = inflight && cyc == tA;
        exp_err   = exp_ack && t_err;
        exp_we    = '0;
        exp_re    = '0;
        if (inflight && cyc == tT + 1) begin
            cur_off = t_off;
            cur_wd  = t_wd;
            if (t_map) begin
                if (t_we) exp_we[t_ch] = 1'b1;
                else      exp_re[t_ch] = 1'b1;
            end
        end
        if (exp_ack) begin
            if (!t_we) exp_rd = t_err ? 32'hDEADBEEF : t_val;
            if (t_err) begin
                if (m_cnt < 255) m_cnt++;
                m_to   = t_to;
                m_slot = t_slot;
            end
        end
        for (int i = 0; i < NS; i++) s_ready[i] = 1'($urandom_range(0, 1));
        if (inflight && t_map && cyc < tA) s_ready[t_ch] = (t_k >= 0 && cyc == tT + 1 + t_k);
        re = r; we = w; address = a; write_data = wd;
        if (r || w) begin
            if (exp_ready) begin
                slot     = int'(a[12:8]);
                inflight = 1'b1;
                tT       = cyc;
                t_we     = w;
                t_slot   = a[12:8];
                t_off    = a[7:0];
                t_wd     = wd;
`ifdef PERIPH_ROUTER_STATUS_EN
                t_stat   = (slot == 0);
`else
                t_stat   = 1'b0;
`endif
                t_map    = !t_stat && slot >= FS && (slot - FS) < NS;
                t_ch     = slot - FS;
                t_k      = k;
                t_to     = t_map && !(k >= 0 && k <= TO - 1);
                t_err    = (!t_map && !t_stat) || t_to;
                tA       = !t_map ? tT + 2 : (t_to ? tT + 1 + TO : tT + 2 + k);
                t_val    = t_stat ? stat_val(t_off) : rdv;
                if (t_stat && w && t_off == 8'h00) begin
                    m_cnt = 0; m_to = 1'b0; m_drop = 1'b0; m_slot = '0;
                end
                for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
                if (t_map) s_rdata[32*t_ch +: 32] = rdv;
            end else begin
                m_drop = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'h0, 32'h0, 0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("ack", 32'(ack), 32'(exp_ack));
            chk("bus_err", 32'(bus_err), 32'(exp_err));
            chk("read_data", read_data, exp_rd);
            chk("s_we", 32'(s_we), 32'(exp_we));
            chk("s_re", 32'(s_re), 32'(exp_re));
            chk("s_addr", 32'(s_addr), 32'(cur_off));
            chk("s_wdata", s_wdata, cur_wd);
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_read_data"}, read_data, 32'd0);
        chk({tag, "_s_we"}, 32'(s_we), 32'd0);
        chk({tag, "_s_re"}, 32'(s_re), 32'd0);
        chk({tag, "_s_addr"}, 32'(s_addr), 32'd0);
        chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    endtask

    initial begin
        int k_tab[7];
        int r_slot, k, mode;
        logic [7:0]  off;
        logic [13:0] a;
        k_tab = '{0, 0, 1, 2, 3, TO - 1, -1};
        rst_n = 1'b0; re = 1'b0; we = 1'b0; address = '0; write_data = '0;
        s_rdata = '0; s_ready = '0;
        model_reset();
        #2;
        check_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Zero-wait read of slot 2
        step(1'b1, 1'b0, 14'h0204, 32'h0, 0, 32'h12345678);
        idle(1); #1;
        chk("t1_s_re", 32'(s_re), 32'h2);
        chk("t1_s_addr", 32'(s_addr), 32'h04);
        idle(1); #1;
        chk("t1_ack", 32'(ack), 32'd1);
        chk("t1_read_data", read_data, 32'h12345678);
        chk("t1_bus_err", 32'(bus_err), 32'd0);

        // Write with three wait cycles
        step(1'b0, 1'b1, 14'h0300, 32'hA5, 3, 32'h0);
        idle(1); #1;
        chk("t2_s_we", 32'(s_we), 32'h4);
        chk("t2_s_wdata", s_wdata, 32'hA5);
        idle(3); #1;
        chk("t2_no_early_ack", 32'(ack), 32'd0);
        idle(1); #1;
        chk("t2_ack", 32'(ack), 32'd1);
        chk("t2_bus_err", 32'(bus_err), 32'd0);
        chk("t2_read_data_held", read_data, 32'h12345678);

`ifdef PERIPH_ROUTER_STATUS_EN
        step(1'b0, 1'b1, 14'h0000, 32'hFFFF_FFFF, 0, 32'h0);
        idle(1);
`endif
        // Timeout read of slot 4 with a dropped request during the wait
        step(1'b1, 1'b0, 14'h0400, 32'h0, -1, 32'h0);
        idle(1);
        step(1'b1, 1'b0, 14'h0200, 32'h0, 0, 32'h0);
        idle(13);
        idle(1); #1;
        chk("t3_no_early_ack", 32'(ack), 32'd0);
        idle(1); #1;
        chk("t3_ack", 32'(ack), 32'd1);
        chk("t3_bus_err", 32'(bus_err), 32'd1);
        chk("t3_read_data", read_data, 32'hDEADBEEF);

`ifdef PERIPH_ROUTER_STATUS_EN
        step(1'b1, 1'b0, 14'h0000, 32'h0, 0, 32'h0);
        idle(2); #1;
        chk("st_read", read_data, 32'h0004_0301);
        chk("st_bus_err", 32'(bus_err), 32'd0);
        step(1'b0, 1'b1, 14'h0000, 32'h1234, 0, 32'h0);
        idle(1); #1;
        chk("st_no_strobe", 32'(s_we | s_re), 32'd0);
        idle(1);
        step(1'b1, 1'b0, 14'h0000, 32'h0, 0, 32'h0);
        idle(2); #1;
        chk("st_cleared", read_data, 32'd0);
        step(1'b1, 1'b0, 14'h0004, 32'h0, 0, 32'h0);
        idle(2); #1;
        chk("st_num_slaves", read_data, 32'd8);
`else
        step(1'b1, 1'b0, 14'h0010, 32'h0, 0, 32'h0);
        idle(2); #1;
        chk("slot0_bus_err", 32'(bus_err), 32'd1);
`endif

        // Unmapped slot 31
        step(1'b1, 1'b0, 14'h1F00, 32'h0, 0, 32'h0);
        idle(1); #1;
        chk("t4_no_strobe", 32'(s_re), 32'd0);
        idle(1); #1;
        chk("t4_ack", 32'(ack), 32'd1);
        chk("t4_bus_err", 32'(bus_err), 32'd1);

        // Reset asserted mid-WAIT after a dropped request
        step(1'b1, 1'b0, 14'h0404, 32'h0, -1, 32'h0);
        idle(1);
        step(1'b1, 1'b0, 14'h0204, 32'h0, 0, 32'h0);
        idle(2);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(TO + 4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                r_slot = $urandom_range(0, 13);
                if (r_slot == 13) r_slot = 31;
                case ($urandom_range(0, 3))
                    0:       off = 8'h00;
                    1:       off = 8'h04;
                    2:       off = 8'h08;
                    default: off = 8'($urandom);
                endcase
                a    = {1'($urandom_range(0, 1)), 5'(r_slot), off};
                mode = $urandom_range(0, 2);
                k    = k_tab[$urandom_range(0, 6)];
                step(mode != 1, mode != 0, a, $urandom, k, $urandom);
            end else begin
                idle(1);
            end
        end
        idle(TO + 4);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
